// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX-stage divide sequencer: FSM states and divider handshake levels.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } div_state_t;

  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: latches DIV/DIVU operands, drives the divider handshake, stalls until ready.
// Optional feature: DIV_ZERO_TRAP_EN traps zero divisors in IDLE instead of launching the divider.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic        exc_div_zero_o
`endif
);

  div_state_t  state;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        sgn_q;
  logic        zero_trap;
  logic        launch;

`ifdef DIV_ZERO_TRAP_EN
  assign zero_trap      = (state == IDLE) && div_req_i && !flush_i && (reg2_i == '0);
  assign exc_div_zero_o = zero_trap;
`else
  assign zero_trap = 1'b0;
`endif

  assign launch = (state == IDLE) && div_req_i && !flush_i && !zero_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op1_q <= '0;
      op2_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            op1_q <= reg1_i;
            op2_q <= reg2_i;
            sgn_q <= div_signed_i;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i || (div_ready_i == DIV_RESULT_READY)) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Flush wins over a same-cycle ready: the result is dropped and the divider annulled.
  always_comb begin
    div_start_o   = DIV_STOP;
    div_annul_o   = 1'b0;
    div_signed_o  = 1'b0;
    div_opdata1_o = '0;
    div_opdata2_o = '0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = '0;
    lo_o          = '0;
    case (state)
      IDLE: stallreq_o = launch;
      BUSY: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
        end else begin
          div_start_o   = DIV_START;
          div_signed_o  = sgn_q;
          div_opdata1_o = op1_q;
          div_opdata2_o = op2_q;
          if (div_ready_i == DIV_RESULT_READY) begin
            whilo_o = 1'b1;
            hi_o    = div_result_i[63:32];
            lo_o    = div_result_i[31:0];
          end else begin
            stallreq_o = 1'b1;
          end
        end
      end
      DRAIN:   stallreq_o = div_req_i && !flush_i;
      default: ;
    endcase
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

EX-stage divide sequencer for the MiniMIPS core. It accepts DIV/DIVU requests from the execute stage, latches the operands, and drives the iterative divider's start/annul/signed/operand handshake. While the divide runs it stalls the pipeline. When the result arrives it releases the stall and presents the result as a one-cycle HI/LO write. It sits between the EX decode logic and the divider instance; both are instantiated side by side in the EX stage.

## Interface
Parameters:
- none (widths fixed at 32-bit operands, 64-bit result)

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- div_req_i  in  1  EX holds a DIV/DIVU instruction this cycle
- div_signed_i  in  1  1 = DIV, 0 = DIVU
- reg1_i  in  32  dividend (rs)
- reg2_i  in  32  divisor (rt)
- flush_i  in  1  pipeline flush; kills the in-flight divide
- div_result_i  in  64  divider result: {remainder, quotient}
- div_ready_i  in  1  divider result valid; held until start drops
- div_start_o  out  1  start to divider
- div_annul_o  out  1  annul to divider
- div_signed_o  out  1  latched signed flag
- div_opdata1_o  out  32  latched dividend
- div_opdata2_o  out  32  latched divisor
- stallreq_o  out  1  stall request to pipeline control
- whilo_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- exc_div_zero_o  out  1  divide-by-zero exception pulse; present only with DIV_ZERO_TRAP_EN

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE, div_req_i=1, flush_i=0:
  - latch reg1_i, reg2_i and div_signed_i into the operand registers
  - go to BUSY
  - stallreq_o=1 in this cycle (combinational)
- IDLE, no request: all outputs 0.
- BUSY:
  - div_start_o=1; div_opdata*/div_signed_o come from the latched registers and do not change while BUSY
  - stallreq_o=1 until div_ready_i=1
- BUSY with div_ready_i=1:
  - stallreq_o=0, whilo_o=1, hi_o=div_result_i[63:32], lo_o=div_result_i[31:0] (all combinational, same cycle)
  - next state DRAIN
- DRAIN (exactly one cycle):
  - div_start_o=0 so the divider returns to its free state
  - if div_req_i=1 (back-to-back divide), stallreq_o=1
  - next state IDLE
- flush_i=1 in BUSY:
  - div_annul_o=1, div_start_o=0, no HI/LO write
  - next state DRAIN
- flush_i=1 in IDLE: the request is ignored.
- flush_i has priority over div_ready_i in the same cycle: the result is discarded.
- The controller performs no arithmetic. Sign handling and remainder sign follow the divider: quotient truncates toward zero; remainder takes the dividend's sign.
- When whilo_o=0, hi_o and lo_o are 0.

## Timing
- Reset: state=IDLE, operand registers=0. Every output is 0 in the cycle after rst is sampled high.
- Reset mid-divide: the divider resets on the same edge, so no annul is needed.
- Request-to-start latency: 1 cycle (div_start_o rises the cycle after the IDLE request).
- Divider handshake: start is held for the whole divide. Ready is registered and rises about 35 cycles after start. Start drops the cycle after ready is seen.
- Minimum spacing between divides: 1 DRAIN cycle.
- whilo_o lines up with the edge on which the stalled instruction leaves EX.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - an IDLE request with reg2_i==0 does not launch the divider
  - exc_div_zero_o pulses for 1 cycle; no stall; no HI/LO write
  - state stays IDLE
  - exc_div_zero_o port exists
- DIV_ZERO_TRAP_EN undefined:
  - a zero divisor launches normally; the divider returns 0
  - HI=0 and LO=0 are written
  - the exc_div_zero_o port is absent

## Structure
- The state encodings (IDLE/BUSY/DRAIN) and the DivStart/DivStop and DivResultReady constants belong in the shared defines header, next to the existing divider constants.
- There is no sub-module: a single FSM plus operand registers. The divider is a sibling instance wired up by the EX stage.
- Expected size: 150–250 lines.

## Test plan
- DIVU 100/7 -> stall held until ready; whilo_o pulse with LO=14, HI=2; then DRAIN, then IDLE.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF with signed=0 (DIVU) -> LO=0, HI=0x80000000; operands held stable while BUSY even though reg1_i/reg2_i are toggled.
- Flush 10 cycles after start -> div_annul_o=1 for 1 cycle, no whilo_o, DRAIN; a following DIVU 9/3 gives LO=3, HI=0.
- Back-to-back DIVU 8/2 then 8/3 -> exactly one DRAIN cycle with stallreq_o=1 between them; results LO=4 HI=0, then LO=2 HI=2.
- Divisor 0:
  - with DIV_ZERO_TRAP_EN: 1-cycle exc_div_zero_o, no stall
  - without it: HI=LO=0 written
- rst asserted mid-BUSY: all outputs 0 on the next cycle.
